// File: rtl/conv_3x3_layer_ctrl.sv
// Layer sequencer for the conv_3x3 datapath: walks every (oc, ic) pair, fetching a
// kernel then streaming one input channel, and waits for the accumulator per oc.
module conv_3x3_layer_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 64,
    parameter int IMAGE_HEIGHT    = 64,
    parameter int CHANNEL_NUM_IN  = 304,
    parameter int CHANNEL_NUM_OUT = 304,
    parameter int KERNEL_SIZE     = 9,
    localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT,
    localparam int W_ADDR_RAW   = $clog2(CHANNEL_NUM_OUT * CHANNEL_NUM_IN * KERNEL_SIZE),
    localparam int P_ADDR_RAW   = $clog2(CHANNEL_NUM_IN * IMAGE_SIZE),
    localparam int OC_RAW       = $clog2(CHANNEL_NUM_OUT),
    localparam int W_ADDR_WIDTH = (W_ADDR_RAW < 1) ? 1 : W_ADDR_RAW,
    localparam int P_ADDR_WIDTH = (P_ADDR_RAW < 1) ? 1 : P_ADDR_RAW,
    localparam int OC_WIDTH     = (OC_RAW < 1) ? 1 : OC_RAW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    ready_in,
    input  logic                    acc_done,
    output logic                    w_rd_en,
    output logic [W_ADDR_WIDTH-1:0] w_addr,
    output logic                    p_rd_en,
    output logic [P_ADDR_WIDTH-1:0] p_addr,
    output logic                    valid_weight_out,
    output logic                    valid_pxl_out,
    output logic                    ic_first,
    output logic [OC_WIDTH-1:0]     oc_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int IC_RAW   = $clog2(CHANNEL_NUM_IN);
    localparam int K_RAW    = $clog2(KERNEL_SIZE);
    localparam int PX_RAW   = $clog2(IMAGE_SIZE);
    localparam int IC_WIDTH = (IC_RAW < 1) ? 1 : IC_RAW;
    localparam int K_WIDTH  = (K_RAW < 1) ? 1 : K_RAW;
    localparam int PX_WIDTH = (PX_RAW < 1) ? 1 : PX_RAW;

    localparam logic [OC_WIDTH-1:0] OC_LAST = OC_WIDTH'(CHANNEL_NUM_OUT - 1);
    localparam logic [IC_WIDTH-1:0] IC_LAST = IC_WIDTH'(CHANNEL_NUM_IN - 1);
    localparam logic [K_WIDTH-1:0]  K_LAST  = K_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [PX_WIDTH-1:0] PX_LAST = PX_WIDTH'(IMAGE_SIZE - 1);

    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("conv_3x3_layer_ctrl: DATA_WIDTH must be positive");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_WAIT_ACC,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [OC_WIDTH-1:0]     oc_q, oc_d;
    logic [IC_WIDTH-1:0]     ic_q, ic_d;
    logic [K_WIDTH-1:0]      k_q, k_d;
    logic [PX_WIDTH-1:0]     px_q, px_d;
    logic [W_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [P_ADDR_WIDTH-1:0] p_addr_q, p_addr_d;
    logic                    w_rd_c, p_rd_c;
    logic                    valid_w_q, valid_p_q;

    // Both addresses advance by one per accepted read; the weight address runs
    // straight through the whole layer, so no multiply is ever needed.
    always_comb begin
        state_d  = state_q;
        oc_d     = oc_q;
        ic_d     = ic_q;
        k_d      = k_q;
        px_d     = px_q;
        w_addr_d = w_addr_q;
        p_addr_d = p_addr_q;
        w_rd_c   = 1'b0;
        p_rd_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD_W;
                    oc_d     = '0;
                    ic_d     = '0;
                    k_d      = '0;
                    px_d     = '0;
                    w_addr_d = '0;
                    p_addr_d = '0;
                end
            end

            S_LOAD_W: begin
                if (ready_in) begin
                    w_rd_c   = 1'b1;
                    w_addr_d = w_addr_q + W_ADDR_WIDTH'(1);
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = S_STREAM;
                    end else begin
                        k_d = k_q + K_WIDTH'(1);
                    end
                end
            end

            S_STREAM: begin
                if (ready_in) begin
                    p_rd_c = 1'b1;
                    if (px_q == PX_LAST) begin
                        px_d = '0;
                        if (ic_q == IC_LAST) begin
                            p_addr_d = '0;
                            state_d  = S_WAIT_ACC;
                        end else begin
                            ic_d     = ic_q + IC_WIDTH'(1);
                            p_addr_d = p_addr_q + P_ADDR_WIDTH'(1);
                            state_d  = S_LOAD_W;
                        end
                    end else begin
                        px_d     = px_q + PX_WIDTH'(1);
                        p_addr_d = p_addr_q + P_ADDR_WIDTH'(1);
                    end
                end
            end

            S_WAIT_ACC: begin
                if (acc_done) begin
                    if (oc_q == OC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        oc_d     = oc_q + OC_WIDTH'(1);
                        ic_d     = '0;
                        p_addr_d = '0;
                        state_d  = S_LOAD_W;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            oc_q      <= '0;
            ic_q      <= '0;
            k_q       <= '0;
            px_q      <= '0;
            w_addr_q  <= '0;
            p_addr_q  <= '0;
            valid_w_q <= 1'b0;
            valid_p_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            oc_q      <= oc_d;
            ic_q      <= ic_d;
            k_q       <= k_d;
            px_q      <= px_d;
            w_addr_q  <= w_addr_d;
            p_addr_q  <= p_addr_d;
            valid_w_q <= w_rd_c;
            valid_p_q <= p_rd_c;
        end
    end

    // Read strobes follow ready_in combinationally so a stalled cycle issues nothing.
    assign w_rd_en          = w_rd_c;
    assign p_rd_en          = p_rd_c;
    assign w_addr           = w_addr_q;
    assign p_addr           = p_addr_q;
    assign valid_weight_out = valid_w_q;
    assign valid_pxl_out    = valid_p_q;
    assign ic_first         = (state_q == S_STREAM) && (ic_q == '0);
    assign oc_idx           = oc_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_3x3_layer_ctrl.sv
// Bench for conv_3x3_layer_ctrl: a queue of expected reads built from the
// (oc, ic, k / pixel) loop nest is compared against every strobe the DUT issues.
module tb_conv_3x3_layer_ctrl;

    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int CIN  = 2;
    localparam int COUT = 2;
    localparam int KS   = 9;
    localparam int IS   = IW * IH;

    logic       clk = 1'b0;
    logic       reset, start, ready_in, acc_done;
    logic       w_rd_en, p_rd_en, valid_weight_out, valid_pxl_out;
    logic       ic_first, busy, done;
    logic [5:0] w_addr;
    logic [4:0] p_addr;
    logic [0:0] oc_idx;

    conv_3x3_layer_ctrl #(
        .DATA_WIDTH      (16),
        .IMAGE_WIDTH     (IW),
        .IMAGE_HEIGHT    (IH),
        .CHANNEL_NUM_IN  (CIN),
        .CHANNEL_NUM_OUT (COUT),
        .KERNEL_SIZE     (KS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .ready_in         (ready_in),
        .acc_done         (acc_done),
        .w_rd_en          (w_rd_en),
        .w_addr           (w_addr),
        .p_rd_en          (p_rd_en),
        .p_addr           (p_addr),
        .valid_weight_out (valid_weight_out),
        .valid_pxl_out    (valid_pxl_out),
        .ic_first         (ic_first),
        .oc_idx           (oc_idx),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_w;
        int addr;
        int oc;
        int ic;
        bit last_of_oc;
    } rd_t;

    rd_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  prev_w, prev_p, busy_exp, got_last;
    int  done_seen, wait_cnt, oc1_pix;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        assert (act === req) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, req);
        end
    endtask

    task automatic build_layer();
        rd_t e;
        exp_q.delete();
        for (int oc = 0; oc < COUT; oc++) begin
            for (int ic = 0; ic < CIN; ic++) begin
                for (int k = 0; k < KS; k++) begin
                    e = '{1'b1, (oc * CIN + ic) * KS + k, oc, ic, 1'b0};
                    exp_q.push_back(e);
                end
                for (int p = 0; p < IS; p++) begin
                    e = '{1'b0, ic * IS + p, oc, ic, (ic == CIN - 1) && (p == IS - 1)};
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_w_rd_en"}, w_rd_en, 0);
        chk({tag, "_p_rd_en"}, p_rd_en, 0);
        chk({tag, "_w_addr"}, w_addr, 0);
        chk({tag, "_p_addr"}, p_addr, 0);
        chk({tag, "_valid_w"}, valid_weight_out, 0);
        chk({tag, "_valid_p"}, valid_pxl_out, 0);
        chk({tag, "_ic_first"}, ic_first, 0);
        chk({tag, "_oc_idx"}, oc_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // One clock cycle: drive inputs, check at the falling edge, return just after the rising edge.
    task automatic step(input bit st, input bit rdy, input bit ad);
        rd_t e;
        start    = st;
        ready_in = rdy;
        acc_done = ad;
        got_last = 1'b0;
        @(negedge clk);
        chk("valid_w_delay", valid_weight_out, prev_w);
        chk("valid_p_delay", valid_pxl_out, prev_p);
        chk("rd_mutex", w_rd_en & p_rd_en, 0);
        chk("busy", busy, busy_exp);
        if (!rdy) begin
            chk("w_rd_stall", w_rd_en, 0);
            chk("p_rd_stall", p_rd_en, 0);
        end
        if (w_rd_en || p_rd_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_kind", w_rd_en, e.is_w);
                if (e.is_w) chk("w_addr", w_addr, e.addr);
                else        chk("p_addr", p_addr, e.addr);
                chk("oc_idx", oc_idx, e.oc);
                chk("ic_first", ic_first, !e.is_w && (e.ic == 0));
                if (!e.is_w && e.oc == 1) oc1_pix++;
                got_last = e.last_of_oc;
            end
        end else if (!busy_exp || wait_cnt > 0) begin
            chk("ic_first_idle", ic_first, 0);
        end
        if (done) done_seen++;
        prev_w = w_rd_en;
        prev_p = p_rd_en;
        if (st && !busy_exp) busy_exp = 1'b1;
        else if (done)       busy_exp = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // mode 1: ready always high; 2: ready random; 3: stray start/acc_done injected.
    task automatic run_layer(input int mode, input int abort_n);
        bit ad, st, rdy;
        done_seen = 0;
        wait_cnt  = 0;
        oc1_pix   = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 3000 && done_seen == 0; cyc++) begin
            if (abort_n > 0 && oc1_pix >= abort_n) break;
            rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            ad  = (wait_cnt == 3);
            st  = 1'b0;
            if (mode == 3) begin
                if (cyc == 5 || cyc == 40 || cyc == 70) st = 1'b1;
                if (cyc == 3 || cyc == 28) ad = 1'b1;
            end
            step(st, rdy, ad);
            if (ad && wait_cnt == 3) wait_cnt = 0;
            else if (got_last)       wait_cnt = 1;
            else if (wait_cnt > 0)   wait_cnt++;
        end
    endtask

    task automatic finish_layer(input string tag);
        chk({tag, "_done_count"}, done_seen, 1);
        chk({tag, "_reads_left"}, exp_q.size(), 0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        chk({tag, "_no_extra_done"}, done_seen, 1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b1;
        ready_in = 1'b1;
        acc_done = 1'b0;
        prev_w   = 1'b0;
        prev_p   = 1'b0;
        busy_exp = 1'b0;
        wait_cnt = 0;
        @(posedge clk);
        #1;
        check_all_zero("reset_over_start");
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        build_layer();
        run_layer(1, 0);
        finish_layer("basic");

        build_layer();
        run_layer(2, 0);
        finish_layer("rand_ready");

        build_layer();
        run_layer(3, 0);
        finish_layer("stray_inputs");

        build_layer();
        run_layer(1, 5);
        chk("abort_in_oc1", oc1_pix, 5);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        chk("abort_no_done", done_seen, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        prev_w   = 1'b0;
        prev_p   = 1'b0;
        busy_exp = 1'b0;
        wait_cnt = 0;
        build_layer();
        run_layer(1, 0);
        finish_layer("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
